// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the MIPS pipeline control block: sequencer state
// encodings and the architectural register-index width.
package mips_ctrl_defs;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: derives every
// stage load enable and bubble request, tracks memory waits and halt.
module pipeline_ctrl
    import mips_ctrl_defs::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    input  logic                 wb_halt,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 mem_wb_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 halted,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int              WCNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    ctrl_state_t       state, next_state;
    logic [WCNT_W-1:0] wcnt;
    logic              load_use;
    logic              do_halt, do_freeze, do_advance;
    logic              stall_inc, flush_inc;
    logic              wcnt_load, wcnt_inc, err_set, err_clr;

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= next_state;
            if (wcnt_load) begin
                wcnt <= WCNT_W'(1);
            end else if (wcnt_inc) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
            if (err_set) begin
                mem_err <= 1'b1;
            end else if (err_clr) begin
                mem_err <= 1'b0;
            end
        end
    end

    always_comb begin : next_state_logic
        next_state = state;
        case (state)
            RUN: begin
                if (wb_halt)                     next_state = HALT;
                else if (mem_req && !dmem_ready) next_state = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (wb_halt)                     next_state = HALT;
                else if (!dmem_ready)            next_state = (wcnt == WCNT_MAX) ? HALT : MEM_WAIT;
                else                             next_state = RUN;
            end
            HALT: begin
                if (resume)                      next_state = RUN;
            end
            default:                             next_state = RUN;
        endcase
    end

    always_comb begin : output_logic
        do_halt    = 1'b0;
        do_freeze  = 1'b0;
        do_advance = 1'b0;
        wcnt_load  = 1'b0;
        wcnt_inc   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            RUN: begin
                if (wb_halt) begin
                    do_halt = 1'b1;
                end else if (mem_req && !dmem_ready) begin
                    do_freeze = 1'b1;
                    wcnt_load = 1'b1;
                end else begin
                    do_advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (wb_halt) begin
                    do_halt = 1'b1;
                end else if (!dmem_ready) begin
                    do_freeze = 1'b1;
                    err_set   = (wcnt == WCNT_MAX);
                    wcnt_inc  = (wcnt != WCNT_MAX);
                end else begin
                    do_advance = 1'b1;
                end
            end
            HALT:    err_clr = resume;
            default: ;
        endcase

        pc_write     = (state != HALT);
        if_id_write  = (state != HALT);
        id_ex_write  = (state != HALT);
        ex_mem_write = (state != HALT);
        mem_wb_write = (state != HALT);
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (do_halt) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (do_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            stall_inc    = 1'b1;
        end else if (do_advance) begin
            // A taken branch squashes the dependent instruction, so it beats load-use.
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall_inc   = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
                flush_inc   = 1'b1;
            end
        end

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            mem_wb_flush = 1'b0;
            stall_inc    = 1'b0;
            flush_inc    = 1'b0;
        end
    end

    assign halted = reset && (state == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (1'b0),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle rule table in RUN plus
// hand-written memory-wait, timeout, halt, reset and saturation sequences.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    // {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id, id_ex, ex_mem, mem_wb flushes}
    localparam logic [8:0] P_DEF  = 9'b11111_0000;
    localparam logic [8:0] P_LU   = 9'b00111_0100;
    localparam logic [8:0] P_BR   = 9'b11111_1100;
    localparam logic [8:0] P_JMP  = 9'b11111_1000;
    localparam logic [8:0] P_FRZ  = 9'b00001_0001;
    localparam logic [8:0] P_WBH  = 9'b01111_1110;
    localparam logic [8:0] P_ZERO = 9'b00000_0000;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
    logic mem_req, dmem_ready, wb_halt, resume;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [8:0] ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .wb_halt(wb_halt), .resume(resume),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .halted(halted), .mem_err(mem_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jmp;
        logic       lr;
        logic [4:0] exrt;
        logic       br;
        logic       mreq;
        logic       rdy;
        logic [8:0] exp_ctrl;
        int         dstall;
        int         dflush;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_req = 0; dmem_ready = 0; wb_halt = 0; resume = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    endtask

    initial begin
        int s0, f0;
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, P_DEF, 0, 0};
        vecs[1]  = '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 0, 0, P_LU,  1, 0};
        vecs[2]  = '{5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0, P_DEF, 0, 0};
        vecs[3]  = '{5'd1, 5'd5, 0, 1, 0, 1, 5'd5, 0, 0, 0, P_LU,  1, 0};
        vecs[4]  = '{5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0, 0, 0, P_DEF, 0, 0};
        vecs[5]  = '{5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 0, 0, 0, P_DEF, 0, 0};
        vecs[6]  = '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 1, 0, 0, P_BR,  0, 1};
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, P_JMP, 0, 1};
        vecs[8]  = '{5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, 0, P_LU,  1, 0};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, P_DEF, 0, 0};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, 0, P_BR,  0, 1};

        clr_in();
        reset = 1'b0;
        #3;
        chk("reset_ctrl", 32'(ctrl), 32'(P_ZERO));
        chk("reset_halted", 32'(halted), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        chk("reset_stall_cnt", 32'(stall_count), 0);
        chk("reset_flush_cnt", 32'(flush_count), 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            clr_in();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            id_jump = vecs[i].jmp; ex_mem_read = vecs[i].lr; ex_rt = vecs[i].exrt;
            ex_branch_taken = vecs[i].br; mem_req = vecs[i].mreq; dmem_ready = vecs[i].rdy;
            #1;
            s0 = int'(stall_count);
            f0 = int'(flush_count);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 0);
            step();
            chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_count), 32'(s0 + vecs[i].dstall));
            chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_count), 32'(f0 + vecs[i].dflush));
        end

        // Three not-ready cycles then release.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memwait_freeze%0d", i), 32'(ctrl), 32'(P_FRZ));
            step();
        end
        dmem_ready = 1;
        #1;
        chk("memwait_release_ctrl", 32'(ctrl), 32'(P_DEF));
        step();
        mem_req = 0; dmem_ready = 0;
        #1;
        chk("memwait_back_run", 32'(ctrl), 32'(P_DEF));
        chk("memwait_stall_cnt", 32'(stall_count), 3);
        chk("memwait_no_err", 32'(mem_err), 0);

        // Timeout: MEM_TIMEOUT = 4 gives five freeze cycles then HALT with mem_err.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("timeout_freeze%0d", i), 32'(ctrl), 32'(P_FRZ));
            chk($sformatf("timeout_halted%0d", i), 32'(halted), 0);
            step();
        end
        chk("timeout_halted", 32'(halted), 1);
        chk("timeout_mem_err", 32'(mem_err), 1);
        chk("timeout_halt_ctrl", 32'(ctrl), 32'(P_ZERO));
        chk("timeout_stall_cnt", 32'(stall_count), 5);
        wb_halt = 1; id_jump = 1;
        #1;
        chk("halt_ignores_inputs", 32'(ctrl), 32'(P_ZERO));
        step();
        chk("halt_stall_frozen", 32'(stall_count), 5);
        chk("halt_flush_frozen", 32'(flush_count), 0);
        chk("halt_still_halted", 32'(halted), 1);
        clr_in();
        resume = 1;
        step();
        resume = 0;
        #1;
        chk("resume_halted", 32'(halted), 0);
        chk("resume_mem_err", 32'(mem_err), 0);
        chk("resume_ctrl", 32'(ctrl), 32'(P_DEF));

        // wb_halt from RUN.
        do_reset();
        wb_halt = 1;
        #1;
        chk("wbhalt_ctrl", 32'(ctrl), 32'(P_WBH));
        step();
        wb_halt = 0; ex_branch_taken = 1;
        #1;
        chk("wbhalt_halted", 32'(halted), 1);
        chk("wbhalt_hold_ctrl", 32'(ctrl), 32'(P_ZERO));
        step();
        chk("wbhalt_flush_cnt", 32'(flush_count), 0);
        chk("wbhalt_still_halted", 32'(halted), 1);
        ex_branch_taken = 0; resume = 1;
        step();
        resume = 0;
        #1;
        chk("wbhalt_resume", 32'(halted), 0);
        chk("wbhalt_resume_ctrl", 32'(ctrl), 32'(P_DEF));

        // Reset asserted in the middle of a memory wait.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        step();
        step();
        chk("midwait_stall_cnt", 32'(stall_count), 2);
        reset = 1'b0;
        #1;
        chk("midwait_reset_ctrl", 32'(ctrl), 32'(P_ZERO));
        chk("midwait_reset_stall", 32'(stall_count), 0);
        chk("midwait_reset_halted", 32'(halted), 0);
        mem_req = 0;
        step();
        reset = 1'b1;
        #1;
        chk("midwait_release_ctrl", 32'(ctrl), 32'(P_DEF));
        step();
        chk("midwait_run_ctrl", 32'(ctrl), 32'(P_DEF));
        chk("midwait_run_stall", 32'(stall_count), 0);

        // Counter saturation at 2^CNT_W-1.
        do_reset();
        set_load_use();
        for (int i = 0; i < 17; i++) step();
        chk("stall_saturate", 32'(stall_count), 32'((1 << CNT_W) - 1));
        clr_in();
        for (int i = 0; i < 17; i++) begin
            ex_branch_taken = 1;
            step();
        end
        chk("flush_saturate", 32'(flush_count), 32'((1 << CNT_W) - 1));
        chk("stall_held", 32'(stall_count), 32'((1 << CNT_W) - 1));
        clr_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
